// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Multiplies finish after MUL_LAT cycles; divides run one restoring step per cycle.
module mdu_iter #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             we_hi,
    input  logic             we_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int LMAX = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
    localparam int CW   = $clog2(LMAX) + 1;
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MSUB  = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

    state_e            r_state, w_state_next;
    logic              r_busy;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_op;
    logic [WIDTH-1:0]  r_a, r_b;
    logic [WIDTH-1:0]  r_hi, r_lo;
    logic [WIDTH-1:0]  r_quo, r_rem, r_dvs;

    logic              w_accept, w_done, w_in_div;
    logic [WIDTH-1:0]  w_abs_a, w_abs_b;
    logic              w_mul_signed;
    logic [2*WIDTH-1:0] w_ext_a, w_ext_b, w_prod, w_mul_res;
    logic [WIDTH:0]    w_shift;
    logic              w_ge;
    logic [WIDTH-1:0]  w_quo_next, w_rem_next;
    logic              w_div_signed, w_q_neg, w_r_neg;
    logic [WIDTH-1:0]  w_div_hi, w_div_lo;

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

    assign w_accept = start && !r_busy && !flush && (op <= OP_MSUB);
    assign w_in_div = (op == OP_DIV) || (op == OP_DIVU);

    // The divider works on magnitudes; signs are restored at write-back.
    assign w_abs_a = ((op == OP_DIV) && a[WIDTH-1]) ? -a : a;
    assign w_abs_b = ((op == OP_DIV) && b[WIDTH-1]) ? -b : b;

    assign w_mul_signed = (r_op == OP_MULT) || (r_op == OP_MADD) || (r_op == OP_MSUB);
    assign w_ext_a = w_mul_signed ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
    assign w_ext_b = w_mul_signed ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
    assign w_prod  = w_ext_a * w_ext_b;

    always_comb begin
        w_mul_res = w_prod;
        if (r_op == OP_MADD)      w_mul_res = {r_hi, r_lo} + w_prod;
        else if (r_op == OP_MSUB) w_mul_res = {r_hi, r_lo} - w_prod;
    end

    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_ge       = (w_shift >= {1'b0, r_dvs});
    assign w_rem_next = w_ge ? (w_shift[WIDTH-1:0] - r_dvs) : w_shift[WIDTH-1:0];
    assign w_quo_next = {r_quo[WIDTH-2:0], w_ge};

    // Overflow (most-negative / -1) falls out naturally: magnitude quotient is 2^(W-1), sign positive.
    assign w_div_signed = (r_op == OP_DIV);
    assign w_q_neg  = w_div_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
    assign w_r_neg  = w_div_signed && r_a[WIDTH-1];
    assign w_div_lo = (r_b == '0) ? '1  : (w_q_neg ? -w_quo_next : w_quo_next);
    assign w_div_hi = (r_b == '0) ? r_a : (w_r_neg ? -w_rem_next : w_rem_next);

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        w_state_next = r_state;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: if (w_accept) w_state_next = w_in_div ? S_DIV : S_MUL;
            S_MUL: begin
                if (flush) w_state_next = S_IDLE;
                else if (r_cnt == MUL_LAST) begin
                    w_state_next = S_IDLE;
                    w_done       = 1'b1;
                end
            end
            S_DIV: begin
                if (flush) w_state_next = S_IDLE;
                else if (r_cnt == DIV_LAST) begin
                    w_state_next = S_IDLE;
                    w_done       = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != S_IDLE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_op  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_quo <= '0;
            r_rem <= '0;
            r_dvs <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else begin
            if (w_accept) begin
                r_cnt <= '0;
                r_op  <= op;
                r_a   <= a;
                r_b   <= b;
                r_quo <= w_abs_a;
                r_rem <= '0;
                r_dvs <= w_abs_b;
            end else if (r_state != S_IDLE) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_state == S_DIV) begin
                    r_quo <= w_quo_next;
                    r_rem <= w_rem_next;
                end
            end

            if (w_done) begin
                if (r_state == S_MUL) {r_hi, r_lo} <= w_mul_res;
                else                  {r_hi, r_lo} <= {w_div_hi, w_div_lo};
            end else if (!r_busy && !w_accept && !flush) begin
                if (we_hi) r_hi <= wdata;
                if (we_lo) r_lo <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: stimulus pushes expected HI/LO/latency,
// a negedge monitor pops and compares on every busy fall.
module tb_mdu_iter;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MSUB  = 3'b101;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0, b = '0;
    logic        flush = 1'b0;
    logic        we_hi = 1'b0, we_lo = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   busy_cnt = 0;
    bit   prev_busy = 1'b0;

    mdu_iter #(.WIDTH(32), .MUL_LAT(5)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .we_hi(we_hi), .we_lo(we_lo), .wdata(wdata),
        .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_busy = 1'b0;
            busy_cnt  = 0;
        end else begin
            if (busy) busy_cnt++;
            else if (prev_busy) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_underflow: busy fell with no expected entry");
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_hi"}, 64'(hi), 64'(e.hi));
                    check({e.name, "_lo"}, 64'(lo), 64'(e.lo));
                    check({e.name, "_lat"}, 64'(busy_cnt), 64'(e.lat));
                end
                busy_cnt = 0;
            end
            prev_busy = busy;
        end
    end

    // Called right after a negedge; returns one negedge later with start dropped.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el, input int lat,
                         input string nm, input bit push);
        exp_t e;
        start = 1'b1; op = o; a = x; b = y;
        if (push) begin
            e.hi = eh; e.lo = el; e.lat = lat; e.name = nm;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0; op = '0; a = '0; b = '0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle: busy still %0b after %0d cycles", busy, k);
        end
    endtask

    task automatic mt(input bit h, input bit l, input logic [31:0] d);
        we_hi = h; we_lo = l; wdata = d;
        @(negedge clk);
        we_hi = 1'b0; we_lo = 1'b0; wdata = '0;
    endtask

    task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eh, input logic [31:0] el, input int lat,
                       input string nm);
        issue(o, x, y, eh, el, lat, nm, 1'b1);
        wait_idle();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        #2 reset = 1'b0;
        @(negedge clk);

        run(OP_MULT,  32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5,  "mult");
        run(OP_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5,  "multu");
        run(OP_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 32, "div_m7_2");
        run(OP_DIVU,  32'd7,        32'd0, 32'h00000007, 32'hFFFFFFFF, 32, "divu_by0");
        run(OP_DIV,   32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 32, "div_by0");
        run(OP_DIV,   32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 32, "div_7_m2");

        // Overflow, then a second start in the busy-fall cycle.
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 32, "div_ovf", 1'b1);
        wait_idle();
        issue(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 32, "divu_b2b", 1'b1);
        check("b2b_busy", 64'(busy), 64'd1);
        wait_idle();

        mt(1'b1, 1'b0, 32'd0);
        mt(1'b0, 1'b1, 32'd5);
        check("mt_hi", 64'(hi), 64'd0);
        check("mt_lo", 64'(lo), 64'd5);
        run(OP_MADD, 32'd3, 32'd4, 32'd0, 32'd17, 5, "madd");

        mt(1'b1, 1'b1, 32'd0);
        check("mt_both_hi", 64'(hi), 64'd0);
        check("mt_both_lo", 64'(lo), 64'd0);
        run(OP_MSUB, 32'd3, 32'd4, 32'hFFFFFFFF, 32'hFFFFFFF4, 5, "msub");

        mt(1'b1, 1'b0, 32'd0);
        mt(1'b0, 1'b1, 32'hFFFFFFFF);
        run(OP_MADD, 32'd1, 32'd1, 32'd1, 32'd0, 5, "madd_carry");

        // Illegal op code is ignored.
        start = 1'b1; op = 3'b110; a = 32'd1; b = 32'd1;
        @(negedge clk);
        start = 1'b0; op = '0;
        check("illegal_busy", 64'(busy), 64'd0);

        // Flush while idle blocks acceptance and MTHI.
        flush = 1'b1; start = 1'b1; op = OP_MULT; we_hi = 1'b1; wdata = 32'h55;
        @(negedge clk);
        flush = 1'b0; start = 1'b0; we_hi = 1'b0; wdata = '0;
        check("idle_flush_busy", 64'(busy), 64'd0);
        check("idle_flush_hi", 64'(hi), 64'd1);

        // Flush in busy cycle 3; start/we_lo during busy are ignored.
        mt(1'b1, 1'b0, 32'h11);
        mt(1'b0, 1'b1, 32'h22);
        issue(OP_DIV, 32'd100, 32'd3, 32'h11, 32'h22, 3, "flush", 1'b1);
        start = 1'b1; op = OP_MULTU; a = 32'd5; b = 32'd5; we_lo = 1'b1; wdata = 32'hDEAD;
        @(negedge clk);
        start = 1'b0; we_lo = 1'b0; wdata = '0; a = '0; b = '0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("flush_stays_idle", 64'(busy), 64'd0);

        // Asynchronous reset mid-MULT.
        issue(OP_MULT, 32'd9, 32'd9, 32'd0, 32'd0, 5, "aborted", 1'b0);
        #2 reset = 1'b1;
        #1;
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_hi", 64'(hi), 64'd0);
        check("async_rst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        run(OP_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 5, "mult_after_rst");

        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
